// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS core
// Contents: opcode/funct constants, FSM state enum, halt cause encoding,
// ALU operation enum, and decode helper functions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } halt_cause_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_AND = 3'd1,
        ALU_NOR = 3'd2,
        ALU_SLT = 3'd3,
        ALU_SLL = 3'd4
    } alu_op_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_AND) || (fn == FN_NOR) ||
                             (fn == FN_SLT) || (fn == FN_SLL) || (fn == FN_JR);
            OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Address calculation for lw/sw reuses the adder.
    function automatic alu_op_t alu_op_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            case (fn)
                FN_AND:  return ALU_AND;
                FN_NOR:  return ALU_NOR;
                FN_SLT:  return ALU_SLT;
                FN_SLL:  return ALU_SLL;
                default: return ALU_ADD;
            endcase
        end
        if (op == OP_ANDI) return ALU_AND;
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32x32 register file, 2 async reads, 1 sync write
// Ports: clock, reset (sync active-high, clears all registers),
//        rd_addr1/rd_data1, rd_addr2/rd_data2 (combinational reads),
//        wr_en/wr_addr/wr_data (written on rising clock edge).
// Register 0 always reads 0 and ignores writes. A read and write of the
// same register in one cycle returns the old value.
module regfile_32x32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data1,
    input  logic [4:0]  rd_addr2,
    output logic [31:0] rd_data2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == 5'd0) ? 32'h0 : regs[rd_addr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS subset core, unified memory port
// Parameters: RESET_PC (PC after reset), ADDR_WIDTH (mem_addr width),
//             MAX_WAIT (unanswered request cycles before bus-timeout halt).
// Ports: clock, reset (sync active-high);
//        mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
//        halted, halt_cause (00 none, 01 illegal, 10 timeout), dbg_pc.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          MAX_WAIT   = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic [1:0]            halt_cause,
    output logic [31:0]           dbg_pc
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t            state;
    halt_cause_t       cause;
    logic [31:0]       pc, ir, a_reg, b_reg, bt_reg, alu_out, mdr;
    logic [WAIT_W-1:0] wait_cnt;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm = {16'h0, ir[15:0]};

    logic [31:0] rd_data1, rd_data2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // jal links in EXEC; every other write happens in WB.
    assign rf_we    = ((state == ST_EXEC) && (opcode == OP_JAL)) || (state == ST_WB);
    assign rf_waddr = (opcode == OP_JAL)   ? 5'd31 :
                      (opcode == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (opcode == OP_JAL) ? pc :
                      (opcode == OP_LW)  ? mdr : alu_out;

    regfile_32x32 u_regfile (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rs),
        .rd_data1 (rd_data1),
        .rd_addr2 (rt),
        .rd_data2 (rd_data2),
        .wr_en    (rf_we),
        .wr_addr  (rf_waddr),
        .wr_data  (rf_wdata)
    );

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_result;

    assign alu_op = alu_op_of(opcode, funct);

    always_comb begin
        alu_b = b_reg;
        case (opcode)
            OP_ANDI:              alu_b = zext_imm;
            OP_ADDI, OP_LW, OP_SW: alu_b = sext_imm;
            default:              alu_b = b_reg;
        endcase
    end

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD: alu_result = a_reg + alu_b;
            ALU_AND: alu_result = a_reg & alu_b;
            ALU_NOR: alu_result = ~(a_reg | alu_b);
            ALU_SLT: alu_result = {31'h0, $signed(a_reg) < $signed(alu_b)};
            ALU_SLL: alu_result = alu_b << shamt;
            default: alu_result = 32'h0;
        endcase
    end

    // Last tolerated unanswered cycle of a pending request.
    logic timeout;
    assign timeout = !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_FETCH;
            cause    <= CAUSE_NONE;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            a_reg    <= 32'h0;
            b_reg    <= 32'h0;
            bt_reg   <= 32'h0;
            alu_out  <= 32'h0;
            mdr      <= 32'h0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        pc       <= pc + 32'd4;
                        wait_cnt <= '0;
                        state    <= ST_DECODE;
                    end else if (timeout) begin
                        cause <= CAUSE_TIMEOUT;
                        state <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    a_reg  <= rd_data1;
                    b_reg  <= rd_data2;
                    bt_reg <= pc + (sext_imm << 2);
                    if (is_legal(opcode, funct)) begin
                        state <= ST_EXEC;
                    end else begin
                        cause <= CAUSE_ILLEGAL;
                        state <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == FN_JR) begin
                                pc    <= a_reg;
                                state <= ST_FETCH;
                            end else begin
                                alu_out <= alu_result;
                                state   <= ST_WB;
                            end
                        end
                        OP_ADDI, OP_ANDI: begin
                            alu_out <= alu_result;
                            state   <= ST_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= alu_result;
                            state   <= ST_MEM;
                        end
                        OP_BEQ: begin
                            if (a_reg == b_reg) pc <= bt_reg;
                            state <= ST_FETCH;
                        end
                        OP_JAL: begin
                            pc    <= {pc[31:28], ir[25:0], 2'b00};
                            state <= ST_FETCH;
                        end
                        default: state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (opcode == OP_LW) begin
                            mdr   <= mem_rdata;
                            state <= ST_WB;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else if (timeout) begin
                        cause <= CAUSE_TIMEOUT;
                        state <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Bus outputs are gated by reset so an aborted transfer drops immediately.
    logic [31:0] addr_sel;
    assign addr_sel   = (state == ST_MEM) ? alu_out : pc;
    assign mem_req    = !reset && ((state == ST_FETCH) || (state == ST_MEM));
    assign mem_we     = !reset && (state == ST_MEM) && (opcode == OP_SW);
    assign mem_addr   = addr_sel[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
    assign mem_wdata  = b_reg;
    assign halted     = !reset && (state == ST_HALT);
    assign halt_cause = reset ? 2'b00 : cause;
    assign dbg_pc     = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench for mips_multicycle_core
module tb_mips_multicycle_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;
    logic [1:0]  halt_cause;

    mips_multicycle_core #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (32),
        .MAX_WAIT   (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .halted     (halted),
        .halt_cause (halt_cause),
        .dbg_pc     (dbg_pc)
    );

    always #5 clock = ~clock;

    logic [31:0] prog [0:255];
    logic [31:0] mem  [0:255];
    int          wcnt = 0;
    int          cyc  = 0;
    int          ready_delay = 0;
    logic        ready_en = 1'b1;

    // Memory responder: program image is copied in while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            wcnt <= 0;
            cyc  <= 0;
        end else begin
            if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
            wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
            cyc  <= cyc + 1;
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && ready_en && (wcnt >= ready_delay);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } sb_t;

    sb_t         sb_q [$];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          chk_cnt  = 0;
    logic        prev_wait = 1'b0;
    logic [64:0] prev_bus;

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int c);
        sb_t e;
        e.addr = addr; e.we = we; e.wdata = wdata; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] addr, input int c);
        push(addr, 1'b0, 32'h0, c);
    endtask

    // Called at each falling edge: pops the scoreboard on completed transfers
    // and checks that a waiting request holds its outputs.
    task automatic monitor();
        sb_t e;
        if (mem_req && prev_wait) check("bus_stable", {mem_addr, mem_we, mem_wdata}, prev_bus);
        if (mem_req && mem_ready) begin
            check("xfer_expected", (sb_q.size() > 0), 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("xfer_addr", mem_addr, e.addr);
                check("xfer_we", mem_we, e.we);
                if (e.we) check("xfer_wdata", mem_wdata, e.wdata);
                if (e.cyc >= 0) check("xfer_cycle", cyc, e.cyc);
            end
        end
        prev_wait = mem_req && !mem_ready;
        prev_bus  = {mem_addr, mem_we, mem_wdata};
    endtask

    task automatic fill_prog();
        for (int i = 0; i < 256; i++) prog[i] = ILLEGAL;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cause", halt_cause, 2'b00);
        check("rst_pc", dbg_pc, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        prev_wait = 1'b0;
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            monitor();
            n++;
        end
        check("halt_reached", halted, 1'b1);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        int reqs;
        int n;

        // ALU chain, zero-wait timing, R0 discard, illegal halt
        fill_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        prog[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        prog[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        prog[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        prog[5] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0084);
        ready_delay = 0;
        ready_en    = 1'b1;
        do_reset();
        fetch(32'h00, 0);
        fetch(32'h04, 4);
        fetch(32'h08, 8);
        fetch(32'h0C, 12);
        fetch(32'h10, 16);
        push(32'h80, 1'b1, 32'd2, 19);
        fetch(32'h14, 20);
        push(32'h84, 1'b1, 32'd0, 23);
        fetch(32'h18, 24);
        run_until_halt(100);
        check("ill_cause", halt_cause, 2'b01);
        check("ill_pc", dbg_pc, 32'h1C);
        repeat (4) begin
            @(negedge clock);
            monitor();
        end
        check("halt_mem_req", mem_req, 1'b0);
        check("halt_pc_frozen", dbg_pc, 32'h1C);

        // sw/lw with three wait cycles per transfer
        fill_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        prog[1] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        prog[2] = 32'hDEAD_BEEF;
        prog[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0008);
        prog[5] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
        prog[6] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0088);
        ready_delay = 3;
        do_reset();
        fetch(32'h00, -1);
        fetch(32'h04, -1);
        fetch(32'h10, -1);
        push(32'h08, 1'b1, 32'd2, -1);
        fetch(32'h14, -1);
        fetch(32'h08, -1);
        fetch(32'h18, -1);
        push(32'h88, 1'b1, 32'd2, -1);
        fetch(32'h1C, -1);
        run_until_halt(300);
        check("ill_cause_b", halt_cause, 2'b01);

        // branches, jal/jr, slt/nor/and/andi/sll
        fill_prog();
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2]  = enc_r(6'h00, 5'd0, 5'd1, 5'd5, 5'd4);
        prog[3]  = enc_i(6'h04, 5'd1, 5'd2, 16'd7);
        prog[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        prog[7]  = enc_i(6'h08, 5'd0, 5'd7, 16'hFFFF);
        prog[8]  = {6'h03, 26'h40};
        prog[64] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        prog[9]  = enc_r(6'h2A, 5'd7, 5'd1, 5'd8, 5'd0);
        prog[10] = enc_r(6'h27, 5'd0, 5'd0, 5'd9, 5'd0);
        prog[11] = enc_r(6'h24, 5'd9, 5'd5, 5'd10, 5'd0);
        prog[12] = enc_i(6'h0C, 5'd7, 5'd11, 16'h8001);
        prog[13] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0080);
        prog[14] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0084);
        prog[15] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0088);
        prog[16] = enc_i(6'h2B, 5'd0, 5'd11, 16'h008C);
        ready_delay = 0;
        do_reset();
        fetch(32'h00, -1);
        fetch(32'h04, -1);
        fetch(32'h08, -1);
        fetch(32'h0C, -1);
        fetch(32'h10, -1);
        fetch(32'h1C, -1);
        fetch(32'h20, -1);
        fetch(32'h100, -1);
        fetch(32'h24, -1);
        fetch(32'h28, -1);
        fetch(32'h2C, -1);
        fetch(32'h30, -1);
        fetch(32'h34, -1);
        push(32'h80, 1'b1, 32'h24, -1);
        fetch(32'h38, -1);
        push(32'h84, 1'b1, 32'h1, -1);
        fetch(32'h3C, -1);
        push(32'h88, 1'b1, 32'h10, -1);
        fetch(32'h40, -1);
        push(32'h8C, 1'b1, 32'h8001, -1);
        fetch(32'h44, -1);
        run_until_halt(200);

        // reset aborts a stalled fetch, then bus timeout after 4 request cycles
        ready_en = 1'b0;
        do_reset();
        repeat (2) begin
            @(negedge clock);
            monitor();
        end
        reset = 1'b1;
        #1 check("abort_mem_req", mem_req, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        prev_wait = 1'b0;
        reqs = 0;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clock);
            monitor();
            if (mem_req) reqs++;
            n++;
        end
        check("timeout_halted", halted, 1'b1);
        check("timeout_cause", halt_cause, 2'b10);
        check("timeout_req_cycles", reqs, 4);
        check("timeout_mem_req", mem_req, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter ADDR_WIDTH, default 32, width of mem_addr (low ADDR_WIDTH bits of the byte address).
REQ-003 Parameter MAX_WAIT, default 255, mem_ready wait cycles before bus-timeout halt.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 mem_req  output  1  memory transfer request.
REQ-008 mem_we  output  1  1 = store, 0 = load/fetch.
REQ-009 mem_addr  output  ADDR_WIDTH  byte address, word aligned.
REQ-010 mem_wdata  output  32  store data.
REQ-011 mem_rdata  input  32  read data, valid in the mem_ready cycle.
REQ-012 mem_ready  input  1  transfer completes in this cycle when mem_req=1.
REQ-013 halted  output  1  core stopped (illegal opcode or bus timeout).
REQ-014 halt_cause  output  2  00 none, 01 illegal instruction, 10 bus timeout.
REQ-015 dbg_pc  output  32  current architectural PC.

Function
REQ-016 ISA SHALL be: add, and, nor, slt, sll, jr (opcode 0, funct 20/24/27/2A/00/08 hex); addi 08, andi 0C, lw 23, sw 2B, beq 04, jal 03.
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; one unified memory port serves fetch and data.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready latch IR, PC<=PC+4, go DECODE; otherwise hold all outputs stable.
REQ-019 DECODE: latch A=R[rs], B=R[rt], BT=PC+(sext(imm)<<2); illegal opcode/funct -> HALT, cause 01.
REQ-020 EXEC: R/I ALU op -> WB; lw/sw compute R[rs]+sext(imm) -> MEM; beq: if A==B then PC<=BT, -> FETCH; jal: R[31]<=PC, PC<={PC[31:28],target,2'b00}, -> FETCH; jr: PC<=A, -> FETCH.
REQ-021 MEM: mem_req=1, mem_addr=effective address; sw: mem_we=1, mem_wdata=B, -> FETCH on ready; lw: latch mem_rdata -> WB on ready.
REQ-022 WB: write rd (R-type), rt (addi/andi/lw); -> FETCH.
REQ-023 Latency with zero-wait memory: beq/jal/jr 3 cycles, R/I ALU and sw 4, lw 5; each wait cycle adds 1.
REQ-024 andi zero-extends imm; addi/lw/sw/beq sign-extend; add/addi wrap modulo 2^32, no overflow trap; slt signed; sll uses shamt.
REQ-025 Writes to R[0] SHALL be discarded; R[0] reads 0 always.
REQ-026 Same-cycle read and write of one register: read returns old value (no bypass needed; FSM never overlaps).
REQ-027 mem_req low in DECODE, EXEC, WB, HALT; mem_we low except MEM of sw.
REQ-028 Wait counter counts consecutive mem_req cycles without mem_ready; at MAX_WAIT -> HALT, cause 10, request dropped.
REQ-029 HALT is terminal until reset; mem_ready ignored; dbg_pc frozen at faulting instruction PC+4.
REQ-030 Misaligned jr target or effective address: low two bits forced to 00 on mem_addr, no trap.

Reset
REQ-031 reset SHALL set state FETCH, PC=RESET_PC, IR=0, wait counter 0, halted=0, halt_cause=00, mem_req=0 in the reset cycle.
REQ-032 Register file contents SHALL be cleared to 0 on reset.
REQ-033 reset mid-transfer SHALL abort it; a mem_ready in the reset cycle is ignored.
REQ-034 First fetch request SHALL appear in the cycle after reset deasserts.

Structure
REQ-035 Shared package mips_pkg SHALL hold opcode/funct constants, FSM state enum, halt_cause encoding, ALU-op enum.
REQ-036 Sub-module regfile_32x32 (2 async read, 1 sync write, $0 hardwired) SHALL be instantiated; ALU stays inline.

Verification
REQ-037 Reset, zero-wait memory, addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> R3=2; third instruction fetched at cycle 8.
REQ-038 sw $3,8($0) then lw $4,8($0), mem_ready delayed 3 cycles per transfer -> write at addr 8 data 2, R4=2, outputs stable during waits.
REQ-039 beq $1,$1,+2 at PC 0x10 -> next fetch 0x1C; beq $1,$2 not equal -> next fetch 0x14.
REQ-040 jal 0x40 at PC 0x20 -> R31=0x24, next fetch 0x100; jr $31 -> next fetch 0x24.
REQ-041 Fetch word 0xFC000000 (illegal) -> halted=1, cause 01, mem_req stays 0; reset -> fetch at RESET_PC.
REQ-042 mem_ready held 0 on fetch, MAX_WAIT=4 -> halted=1, cause 10 after 4 request cycles; addi $0,$0,7 earlier leaves R0=0.
